ff_bank: RTL and testbench
==========================

# ff_bank

Parametrised bank of WIDTH independent single-bit storage elements, each channel selectable at run time as SR, JK, D-with-enable or T flip-flop. Global synchronous clear and preset are included, along with per-channel change strobes and a sticky log plus saturating counter of illegal SR input combinations (S=R=1). It serves as the general-purpose control/status flag register for the datapath blocks and replaces single-bit hand-built SR flip-flops.

## Interface
- WIDTH, 8: number of channels (1..64).
- CNT_W, 8: width of the conflict counter.
- SR_POL, 0: SR-mode resolution of S=R=1. 0 = reset-dominant (q<=0), 1 = set-dominant (q<=1), 2 = hold.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high; highest priority.
- clr  in  1  synchronous clear of all q to 0.
- pre  in  1  synchronous preset of all q to 1.
- mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]. 00=SR, 01=JK, 10=D, 11=T.
- a  in  WIDTH  per-channel input 1: S / J / D / T.
- b  in  WIDTH  per-channel input 2: R / K / enable / unused.
- q  out  WIDTH  registered state.
- qn  out  WIDTH  combinational ~q.
- chg  out  WIDTH  registered; chg[i]=1 in exactly the cycle q[i] presents a new value.
- conflict  out  WIDTH  sticky per-channel flag: SR-mode channel saw a=b=1.
- conflict_cnt  out  CNT_W  saturating count of cycles with any new SR conflict.
- conflict_clr  in  1  synchronous clear of conflict and conflict_cnt.

## Operation
- Reset values: q=0, qn=all 1, chg=0, conflict=0, conflict_cnt=0.
- Priority per edge: rst > clr > pre > per-channel mode logic. If clr=pre=1, clr wins.
- While clr or pre is active, a/b are ignored and no conflict is logged.
- Per-channel next state, with q = the current value:
  - SR: 10→1, 01→0, 00→hold, 11→per SR_POL.
  - JK: 10→1, 01→0, 00→hold, 11→toggle.
  - D: b=1 → q<=a; b=0 → hold.
  - T: a=1 → toggle; a=0 → hold; b ignored.
- Mode may change on any cycle. The new mode applies to the same edge's inputs, and q carries over unchanged.
- chg[i] <= (next q[i] != q[i]). chg is forced to 0 on a rst edge, even if q changes.
- Conflict logging applies only to SR-mode channels with a=b=1, when not in rst/clr/pre:
  - The channel's conflict bit is set.
  - conflict_cnt increments by 1 if any channel conflicts that cycle. It increments once per cycle regardless of how many channels conflict, and holds at 2^CNT_W-1.
- conflict_clr=1 clears conflict and conflict_cnt. If a new conflict occurs in the same cycle, the new conflict wins: the affected bits end up 1 and the count ends up 1.
- JK 11 and D/T modes never log conflicts.

## Timing
- All outputs except qn are registered, with one-cycle latency from input to q/chg/conflict/conflict_cnt.
- qn follows q combinationally within the same cycle.
- rst asserted mid-operation takes effect on the next edge with no partial update. The first post-reset edge with rst=0 uses normal logic.
- No handshake applies: inputs are sampled on every edge, with no hold or stall.
- Counter arithmetic is unsigned CNT_W bits, with saturation and no wrap.

## Test plan
- Reset then SR sweep: WIDTH=8, all mode=00. Apply a=0x01,b=0 → q=0x01, chg=0x01. Then a=0,b=0 → q=0x01, chg=0. Then a=0,b=0x01 → q=0x00, chg=0x01.
- SR conflict per SR_POL: a=b=0x01 from q=0. SR_POL=0 gives q=0. SR_POL=1 gives q=1. SR_POL=2 gives q=0 (hold). All three give conflict=0x01 and conflict_cnt=1.
- Mixed modes: mode=0xE4 (ch0 SR, ch1 JK, ch2 D, ch3 T). Hold a=0x0F, b=0x06 for 3 cycles from q=0:
  - ch0 (SR, S=1, R=0): 1,1,1.
  - ch1 (JK, J=K=1): 1,0,1.
  - ch2 (D, en=1, D=1): 1,1,1.
  - ch3 (T, T=1): 1,0,1.
  - conflict stays 0.
- Priority: clr=pre=1 with q=0xFF gives q=0x00, chg=0xFF. Then pre=1 alone gives q=0xFF. Then rst=1 with pre=1 gives q=0, chg=0.
- Counter saturation and clear race: CNT_W=2, 5 consecutive conflict cycles → conflict_cnt=3. conflict_clr together with a new ch2 conflict → conflict=0x04, conflict_cnt=1. conflict_clr alone → 0, 0.
- Conflicts masked: a=b=0xFF in SR mode while clr=1 → conflict stays 0 and conflict_cnt stays 0.

Source files
------------

// File: rtl/ff_bank_if.sv
// ff_bank_if: bundles the control inputs and the flag/status outputs of
// ff_bank so that datapath blocks can pass the whole register around as
// one port. clk and rst stay outside the interface.
interface ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic                 clr;
  logic                 pre;
  logic                 conflict_clr;
  logic [2*WIDTH-1:0]   mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     qn;
  logic [WIDTH-1:0]     chg;
  logic [WIDTH-1:0]     conflict;
  logic [CNT_W-1:0]     conflict_cnt;

  // The block driving the control inputs and consuming the flags.
  modport master (
    output clr, pre, conflict_clr, mode, a, b,
    input  q, qn, chg, conflict, conflict_cnt
  );

  // The flag register itself.
  modport slave (
    input  clr, pre, conflict_clr, mode, a, b,
    output q, qn, chg, conflict, conflict_cnt
  );
endinterface

// File: rtl/ff_bank.sv
// ff_bank: WIDTH independent single-bit flags, each behaving as an SR, JK,
// D-with-enable or T flip-flop depending on its 2-bit mode field. Global
// clear/preset override the per-channel logic. Illegal SR inputs (S=R=1)
// are remembered in a sticky per-channel flag and counted in a saturating
// counter that advances at most once per cycle.
module ff_bank #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int SR_POL = 0
) (
  input logic     clk,
  input logic     rst,
  ff_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [WIDTH-1:0] conflict_hit;

  // Per-channel next state; clr beats pre, and both mask the channel logic
  // so no conflict can be flagged while either is active.
  always_comb begin
    q_d          = q_q;
    conflict_hit = '0;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.pre) begin
      q_d = '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode_e'(bus.mode[2*i +: 2]))
          MODE_SR: begin
            case ({bus.a[i], bus.b[i]})
              2'b10: q_d[i] = 1'b1;
              2'b01: q_d[i] = 1'b0;
              2'b11: begin
                conflict_hit[i] = 1'b1;
                if (SR_POL == 0)      q_d[i] = 1'b0;
                else if (SR_POL == 1) q_d[i] = 1'b1;
                else                  q_d[i] = q_q[i];
              end
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_JK: begin
            case ({bus.a[i], bus.b[i]})
              2'b10:   q_d[i] = 1'b1;
              2'b01:   q_d[i] = 1'b0;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_D: begin
            if (bus.b[i]) q_d[i] = bus.a[i];
          end
          default: begin
            if (bus.a[i]) q_d[i] = ~q_q[i];
          end
        endcase
      end
    end
  end

  // Change strobes and conflict bookkeeping; a new conflict in the same
  // cycle as conflict_clr survives the clear (bits set, count restarts at 1).
  always_comb begin
    chg_d          = q_d ^ q_q;
    conflict_d     = conflict_q;
    conflict_cnt_d = conflict_cnt_q;
    if (bus.conflict_clr) begin
      conflict_d     = '0;
      conflict_cnt_d = '0;
    end
    conflict_d = conflict_d | conflict_hit;
    if (|conflict_hit) begin
      if (conflict_cnt_d != CNT_MAX) conflict_cnt_d = conflict_cnt_d + CNT_ONE;
    end
  end

  // State register; rst wins over everything and also suppresses chg.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q            <= '0;
      chg_q          <= '0;
      conflict_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      q_q            <= q_d;
      chg_q          <= chg_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.q            = q_q;
  assign bus.qn           = ~q_q;
  assign bus.chg          = chg_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: drives three ff_bank instances (SR_POL 0, 1, 2; CNT_W=2) with
// identical directed steps. Each step pushes its expected outcome into a
// scoreboard queue and the entry is popped and compared after the edge.
module tb_ff_bank;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus0 ();
  ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus1 ();
  ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POL(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POL(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    string           tag;
    logic [2:0][7:0] q;
    logic [2:0][7:0] chg;
    logic [7:0]      conf;
    logic [1:0]      cnt;
  } exp_t;

  exp_t sb[$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports a failure with observed/expected.
  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pops the oldest expectation and compares all outputs of all three DUTs.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    checkVal({e.tag, ".q0"},    bus0.q,   e.q[0]);
    checkVal({e.tag, ".qn0"},   bus0.qn,  ~e.q[0]);
    checkVal({e.tag, ".chg0"},  bus0.chg, e.chg[0]);
    checkVal({e.tag, ".conf0"}, bus0.conflict, e.conf);
    checkVal({e.tag, ".cnt0"},  {6'd0, bus0.conflict_cnt}, {6'd0, e.cnt});
    checkVal({e.tag, ".q1"},    bus1.q,   e.q[1]);
    checkVal({e.tag, ".qn1"},   bus1.qn,  ~e.q[1]);
    checkVal({e.tag, ".chg1"},  bus1.chg, e.chg[1]);
    checkVal({e.tag, ".conf1"}, bus1.conflict, e.conf);
    checkVal({e.tag, ".cnt1"},  {6'd0, bus1.conflict_cnt}, {6'd0, e.cnt});
    checkVal({e.tag, ".q2"},    bus2.q,   e.q[2]);
    checkVal({e.tag, ".qn2"},   bus2.qn,  ~e.q[2]);
    checkVal({e.tag, ".chg2"},  bus2.chg, e.chg[2]);
    checkVal({e.tag, ".conf2"}, bus2.conflict, e.conf);
    checkVal({e.tag, ".cnt2"},  {6'd0, bus2.conflict_cnt}, {6'd0, e.cnt});
  endtask

  // Drives one cycle of inputs on the falling edge, records the expected
  // result, then checks it just after the following rising edge.
  task automatic applyStimulus(
    input string      tag,
    input logic       r, c, p, cc,
    input logic [15:0] m,
    input logic [7:0] av, bv,
    input logic [7:0] eq0, eq1, eq2,
    input logic [7:0] ec0, ec1, ec2,
    input logic [7:0] econf,
    input logic [1:0] ecnt
  );
    exp_t e;
    @(negedge clk);
    rst = r;
    bus0.clr = c;  bus1.clr = c;  bus2.clr = c;
    bus0.pre = p;  bus1.pre = p;  bus2.pre = p;
    bus0.conflict_clr = cc; bus1.conflict_clr = cc; bus2.conflict_clr = cc;
    bus0.mode = m; bus1.mode = m; bus2.mode = m;
    bus0.a = av;   bus1.a = av;   bus2.a = av;
    bus0.b = bv;   bus1.b = bv;   bus2.b = bv;
    e.tag = tag;
    e.q[0] = eq0;   e.q[1] = eq1;   e.q[2] = eq2;
    e.chg[0] = ec0; e.chg[1] = ec1; e.chg[2] = ec2;
    e.conf = econf;
    e.cnt  = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Directed sequence; q/chg columns are dut0 (reset-dom), dut1 (set-dom),
  // dut2 (hold).
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.clr = 0; bus1.clr = 0; bus2.clr = 0;
    bus0.pre = 0; bus1.pre = 0; bus2.pre = 0;
    bus0.conflict_clr = 0; bus1.conflict_clr = 0; bus2.conflict_clr = 0;
    bus0.mode = '0; bus1.mode = '0; bus2.mode = '0;
    bus0.a = '0; bus1.a = '0; bus2.a = '0;
    bus0.b = '0; bus1.b = '0; bus2.b = '0;
    $display("[TB] starting ff_bank directed sequence");

    //             tag            r c p cc mode      a      b      q0     q1     q2     chg0   chg1   chg2   conf   cnt
    applyStimulus("reset",       1,0,0,0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    applyStimulus("sr_set",      0,0,0,0, 16'h0000, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 2'd0);
    applyStimulus("sr_hold",     0,0,0,0, 16'h0000, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    applyStimulus("sr_reset",    0,0,0,0, 16'h0000, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 2'd0);
    applyStimulus("sr_conflict", 0,0,0,0, 16'h0000, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 2'd1);
    applyStimulus("rst_mid",     1,0,0,0, 16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    applyStimulus("mix1",        0,0,0,0, 16'h00E4, 8'h0F, 8'h06, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 2'd0);
    applyStimulus("mix2",        0,0,0,0, 16'h00E4, 8'h0F, 8'h06, 8'h05, 8'h05, 8'h05, 8'h0A, 8'h0A, 8'h0A, 8'h00, 2'd0);
    applyStimulus("mix3",        0,0,0,0, 16'h00E4, 8'h0F, 8'h06, 8'h0F, 8'h0F, 8'h0F, 8'h0A, 8'h0A, 8'h0A, 8'h00, 2'd0);
    applyStimulus("pre_fill",    0,0,1,0, 16'h00E4, 8'h0F, 8'h06, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'h00, 2'd0);
    applyStimulus("clr_pre",     0,1,1,0, 16'h00E4, 8'h0F, 8'h06, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 2'd0);
    applyStimulus("pre_only",    0,0,1,0, 16'h00E4, 8'h0F, 8'h06, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 2'd0);
    applyStimulus("rst_pre",     1,0,1,0, 16'h00E4, 8'h0F, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    applyStimulus("sat1",        0,0,0,0, 16'h0000, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 2'd1);
    applyStimulus("sat2",        0,0,0,0, 16'h0000, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 2'd2);
    applyStimulus("sat3",        0,0,0,0, 16'h0000, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 2'd3);
    applyStimulus("sat4",        0,0,0,0, 16'h0000, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 2'd3);
    applyStimulus("sat5",        0,0,0,0, 16'h0000, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 2'd3);
    applyStimulus("clr_race",    0,0,0,1, 16'h0000, 8'h04, 8'h04, 8'h00, 8'h05, 8'h00, 8'h00, 8'h04, 8'h00, 8'h04, 2'd1);
    applyStimulus("clr_only",    0,0,0,1, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    applyStimulus("masked",      0,1,0,0, 16'h0000, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 2'd0);
    applyStimulus("after_mask",  0,0,0,0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
